// File: rtl/kc_pkg.sv
// kc_pkg
//   Shared types and constants for the keycode tracker.
//   kc_state_t : tracker FSM states (IDLE waits for an event, APPLY evaluates it)
//   kc_event_t : one buffered key event {make, code}
//   KEY_*      : HID usage codes used by the motion logic; KEY_NONE marks an
//                empty slot in the packed keycode word.
package kc_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } kc_state_t;

  typedef struct packed {
    logic       make;
    logic [7:0] code;
  } kc_event_t;

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_D    = 8'h07;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_W    = 8'h1A;

endpackage

// File: rtl/kc_event_fifo.sv
// kc_event_fifo
//   Synchronous FIFO of kc_event_t used to absorb bursts of key events.
//   Clk   : system clock, rising edge
//   Reset : synchronous active-low reset; empties the FIFO
//   push  : write din when not full
//   din   : event to write
//   pop   : discard the head entry when not empty
//   full  : no free entries (registered pointer compare)
//   empty : no entries (registered pointer compare)
//   head  : oldest entry, valid while !empty
import kc_pkg::*;

module kc_event_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      Clk,
  input  logic      Reset,
  input  logic      push,
  input  kc_event_t din,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output kc_event_t head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the address bits coincide.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  kc_event_t   mem [FIFO_DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only; the pointers alone define what is valid.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/keycode_tracker.sv
// keycode_tracker
//   Turns a stream of key make/break events into the packed two-key keycode
//   word {slot1, slot0}. Events are buffered in kc_event_fifo, then applied
//   one at a time by a two-state FSM (one event per two cycles).
//   Clk             : system clock, rising edge
//   Reset           : synchronous active-low reset
//   ev_valid        : event present
//   ev_ready        : event can be accepted (FIFO not full)
//   ev_make         : 1 = press, 0 = release
//   ev_code         : HID usage code
//   keycode         : {slot1, slot0}, 8'h00 = empty slot
//   keycode_changed : one-cycle pulse when keycode takes a new value
//   drop_count      : saturating count of presses dropped with both slots full
import kc_pkg::*;

module keycode_tracker #(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ev_valid,
  output logic              ev_ready,
  input  logic              ev_make,
  input  logic [7:0]        ev_code,
  output logic [15:0]       keycode,
  output logic              keycode_changed,
  output logic [DROP_W-1:0] drop_count
);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  kc_state_t state;
  kc_state_t state_nxt;

  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_push;
  logic      fifo_pop;
  kc_event_t fifo_din;
  kc_event_t fifo_head;

  kc_event_t  ev_p0;
  logic [7:0] slot0;
  logic [7:0] slot1;
  logic [7:0] slot0_nxt;
  logic [7:0] slot1_nxt;
  logic       changed_nxt;
  logic       drop_inc;

  assign ev_ready      = ~fifo_full;
  assign fifo_push     = ev_valid & ev_ready;
  assign fifo_din.make = ev_make;
  assign fifo_din.code = ev_code;

  kc_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    slot0_nxt = slot0;
    slot1_nxt = slot1;
    drop_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        state_nxt = IDLE;
        // A zero code is carried through the FIFO but never touches the slots;
        // this also keeps a release of 8'h00 from "matching" an empty slot.
        if (ev_p0.code != KEY_NONE) begin
          if (ev_p0.make) begin
            if (ev_p0.code == slot0 || ev_p0.code == slot1) begin
              // typematic repeat of a held key
            end else if (slot0 == KEY_NONE) begin
              slot0_nxt = ev_p0.code;
            end else if (slot1 == KEY_NONE) begin
              slot1_nxt = ev_p0.code;
            end else begin
              drop_inc = 1'b1;
            end
          end else begin
            // No compaction: the surviving key keeps its slot.
            if (ev_p0.code == slot0) begin
              slot0_nxt = KEY_NONE;
            end else if (ev_p0.code == slot1) begin
              slot1_nxt = KEY_NONE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    changed_nxt = (state == APPLY) && ({slot1_nxt, slot0_nxt} != {slot1, slot0});
  end

  // Stage p0: head event latched while it is popped in IDLE.
  always_ff @(posedge Clk) begin
    if (state == IDLE && !fifo_empty) ev_p0 <= fifo_head;
  end

  // Stage p1: slots, strobe and drop counter updated from the APPLY decision.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state           <= IDLE;
      slot0           <= KEY_NONE;
      slot1           <= KEY_NONE;
      keycode_changed <= 1'b0;
      drop_count      <= '0;
    end else begin
      state           <= state_nxt;
      slot0           <= slot0_nxt;
      slot1           <= slot1_nxt;
      keycode_changed <= changed_nxt;
      if (drop_inc) drop_count <= sat_inc(drop_count);
    end
  end

  assign keycode = {slot1, slot0};

endmodule

// File: tb/tb_keycode_tracker.sv
import kc_pkg::*;

module tb_keycode_tracker;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_make;
  logic [7:0]  ev_code;
  logic [15:0] keycode;
  logic        keycode_changed;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  keycode_tracker #(
    .FIFO_DEPTH (4),
    .DROP_W     (8)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .ev_valid        (ev_valid),
    .ev_ready        (ev_ready),
    .ev_make         (ev_make),
    .ev_code         (ev_code),
    .keycode         (keycode),
    .keycode_changed (keycode_changed),
    .drop_count      (drop_count)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (keycode_changed === 1'b1) strobes <= strobes + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    ev_valid = 1'b0;
    Reset    = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
  endtask

  // Presents one event and returns 1 time unit after the accepting edge.
  task automatic push_ev(input logic mk, input logic [7:0] cd);
    int n;
    ev_valid = 1'b1;
    ev_make  = mk;
    ev_code  = cd;
    n = 0;
    @(negedge Clk);
    while (!ev_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!ev_ready) check("push_timeout", {31'd0, ev_ready}, 32'd1);
    @(posedge Clk);
    #1;
    ev_valid = 1'b0;
  endtask

  logic       bmk [8];
  logic [7:0] bcd [8];
  int         s0;
  logic       saw_full;

  initial begin
    Reset    = 1'b0;
    ev_valid = 1'b0;
    ev_make  = 1'b0;
    ev_code  = 8'h00;
    settle(3);
    Reset = 1'b1;

    // Reset state
    @(negedge Clk);
    check("rst_keycode", keycode, 32'h0);
    check("rst_changed", keycode_changed, 32'h0);
    check("rst_drop", drop_count, 32'h0);
    check("rst_ready", ev_ready, 32'h1);

    // Press W: latency of two edges after acceptance, single-cycle strobe
    settle(1);
    s0 = strobes;
    ev_valid = 1'b1; ev_make = 1'b1; ev_code = KEY_W;
    @(posedge Clk); #1; ev_valid = 1'b0;       // accepted at edge k
    @(negedge Clk);
    check("w_k0_keycode", keycode, 32'h0);
    @(negedge Clk);                              // after k+1
    check("w_k1_keycode", keycode, 32'h0);
    check("w_k1_changed", keycode_changed, 32'h0);
    @(negedge Clk);                              // after k+2
    check("w_k2_keycode", keycode, 32'h001A);
    check("w_k2_changed", keycode_changed, 32'h1);
    @(negedge Clk);
    check("w_k3_changed", keycode_changed, 32'h0);
    settle(1);
    check("w_strobes", strobes - s0, 32'd1);

    // Two keys, release without compaction, refill of slot0
    s0 = strobes;
    push_ev(1'b1, KEY_A); settle(4);
    check("wa_keycode", keycode, 32'h041A);
    push_ev(1'b0, KEY_W); settle(4);
    check("relw_keycode", keycode, 32'h0400);
    push_ev(1'b1, KEY_D); settle(4);
    check("d_keycode", keycode, 32'h0407);
    check("wad_strobes", strobes - s0, 32'd3);

    // Both slots full: drops and saturation
    push_ev(1'b0, KEY_D); settle(4);
    push_ev(1'b1, KEY_W); settle(4);
    check("aw_keycode", keycode, 32'h041A);
    s0 = strobes;
    push_ev(1'b1, KEY_S); settle(4);
    check("drop1_keycode", keycode, 32'h041A);
    check("drop1_count", drop_count, 32'd1);
    check("drop1_strobes", strobes - s0, 32'd0);
    for (int i = 0; i < 300; i++) push_ev(1'b1, KEY_S);
    settle(12);
    check("drop_sat_count", drop_count, 32'd255);
    check("drop_sat_keycode", keycode, 32'h041A);
    check("drop_sat_strobes", strobes - s0, 32'd0);

    // Typematic repeat and release of a key not held
    do_reset();
    @(negedge Clk);
    check("rst2_drop", drop_count, 32'h0);
    check("rst2_keycode", keycode, 32'h0);
    settle(1);
    s0 = strobes;
    push_ev(1'b1, KEY_W);
    push_ev(1'b1, KEY_W);
    push_ev(1'b0, KEY_D);
    settle(10);
    check("rep_keycode", keycode, 32'h001A);
    check("rep_strobes", strobes - s0, 32'd1);

    // Back-to-back burst held on ev_valid; FIFO fills and backpressures
    do_reset();
    bmk[0] = 1'b1; bcd[0] = KEY_W;
    bmk[1] = 1'b1; bcd[1] = KEY_A;
    bmk[2] = 1'b0; bcd[2] = KEY_W;
    bmk[3] = 1'b1; bcd[3] = KEY_S;
    bmk[4] = 1'b0; bcd[4] = KEY_A;
    bmk[5] = 1'b0; bcd[5] = KEY_S;
    bmk[6] = 1'b0; bcd[6] = KEY_D;
    bmk[7] = 1'b0; bcd[7] = KEY_D;
    s0 = strobes;
    saw_full = 1'b0;
    ev_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int n;
      ev_make = bmk[i];
      ev_code = bcd[i];
      n = 0;
      @(negedge Clk);
      while (!ev_ready && n < 20) begin
        saw_full = 1'b1;
        @(negedge Clk);
        n++;
      end
      if (!ev_ready) check("burst_timeout", {31'd0, ev_ready}, 32'd1);
      @(posedge Clk);
      #1;
    end
    ev_valid = 1'b0;
    check("burst_saw_full", {31'd0, saw_full}, 32'd1);
    settle(20);
    check("burst_keycode", keycode, 32'h0000);
    check("burst_strobes", strobes - s0, 32'd6);
    check("burst_ready", ev_ready, 32'h1);

    // Reset while events are pending and the first one is about to apply
    s0 = strobes;
    ev_valid = 1'b1; ev_make = 1'b1; ev_code = KEY_W;
    @(posedge Clk); #1;                          // edge k: W accepted
    ev_code = KEY_A;
    @(posedge Clk); #1;                          // edge k+1: A accepted, W latched
    ev_code = KEY_S;
    Reset = 1'b0;
    @(posedge Clk); #1;                          // edge k+2: reset instead of apply
    ev_valid = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst_keycode", keycode, 32'h0);
    check("mid_rst_changed", keycode_changed, 32'h0);
    check("mid_rst_ready", ev_ready, 32'h1);
    settle(8);
    check("mid_rst_keycode_late", keycode, 32'h0);
    check("mid_rst_strobes", strobes - s0, 32'd0);
    check("mid_rst_drop", drop_count, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
